// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered I/S/B/U/J immediate generator with a valid/ready
// skid buffer and a sideband tag, placed at the decode-to-execute boundary.
// Optional: define ZICSR_IMM_EN to decode Immsrc=101 as the CSR zimm format;
// without it, 101 is reserved like 110/111.

// Combinational extraction for one instruction word.
module imm_gen_pipe_ext #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      src,
  output logic [XLEN-1:0] imm,
  output logic            ill
);
  logic [31:0] v32;

  // Build the 32-bit immediate; every format already carries its own sign fill.
  always_comb begin
    v32 = '0;
    ill = 1'b0;
    case (src)
      3'b000: v32 = {{20{instr[31]}}, instr[31:20]};
      3'b001: v32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010: v32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      3'b011: v32 = {instr[31:12], 12'b0};
      3'b100: v32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef ZICSR_IMM_EN
      3'b101: v32 = {27'b0, instr[19:15]};
`else
      3'b101: ill = 1'b1;
`endif
      default: ill = 1'b1;
    endcase
  end

  // Widen to XLEN. zimm has bit 31 clear, so sign extension also zero-extends it.
  assign imm = XLEN'($signed(v32));
endmodule

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      Instrd,
  input  logic [2:0]       Immsrc,
  input  logic [TAG_W-1:0] Tagd,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [XLEN-1:0]  Immextd,
  output logic [TAG_W-1:0] Tage,
  output logic             imm_illegal,
  output logic             out_valid,
  input  logic             out_ready
);
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } ent_t;

  ent_t nxt, main_q, skid_q;
  logic main_v, skid_v;
  logic take, drain;

  imm_gen_pipe_ext #(.XLEN(XLEN)) u_ext (
    .instr (Instrd),
    .src   (Immsrc),
    .imm   (nxt.imm),
    .ill   (nxt.ill)
  );
  assign nxt.tag = Tagd;

  // in_ready comes straight from the skid flop: no path from out_ready.
  assign in_ready = !skid_v;
  assign take     = in_valid && in_ready;
  assign drain    = main_v && out_ready;

  // Two-entry skid buffer: main feeds the outputs, skid absorbs one stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      // Kill occupancy only; held data stays put and the offered input is dropped.
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (drain) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end
    end else if (take) begin
      if (!main_v || drain) begin
        main_q <= nxt;
        main_v <= 1'b1;
      end else begin
        skid_q <= nxt;
        skid_v <= 1'b1;
      end
    end else if (drain) begin
      main_v <= 1'b0;
    end
  end

  assign Immextd     = main_q.imm;
  assign Tage        = main_q.tag;
  assign imm_illegal = main_q.ill;
  assign out_valid   = main_v;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a vector table streamed back-to-back into
// XLEN=32 and XLEN=64 instances, plus sequences for stall, flush and reset.
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [2:0]  src;
  logic [4:0]  tag;
  logic        in_valid, flush, out_ready;

  logic        rdy32, ill32, ov32;
  logic [31:0] imm32;
  logic [4:0]  tage32;
  logic        rdy64, ill64, ov64;
  logic [63:0] imm64;
  logic [4:0]  tage64;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u32 (
    .clk(clk), .rst_n(rst_n), .Instrd(instr), .Immsrc(src), .Tagd(tag),
    .in_valid(in_valid), .in_ready(rdy32), .flush(flush), .Immextd(imm32),
    .Tage(tage32), .imm_illegal(ill32), .out_valid(ov32), .out_ready(out_ready)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u64 (
    .clk(clk), .rst_n(rst_n), .Instrd(instr), .Immsrc(src), .Tagd(tag),
    .in_valid(in_valid), .in_ready(rdy64), .flush(flush), .Immextd(imm64),
    .Tage(tage64), .imm_illegal(ill64), .out_valid(ov64), .out_ready(out_ready)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [4:0]  tag;
    logic [63:0] exp;
    logic        ill;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] t);
    in_valid = 1'b1; instr = 32'h0000_0013; src = 3'b000; tag = t;
  endtask

  initial begin
    vt[0]  = '{32'hFFF0_0093, 3'b000, 5'd1,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vt[1]  = '{32'h8000_0000, 3'b001, 5'd2,  64'hFFFF_FFFF_FFFF_F800, 1'b0};
    vt[2]  = '{32'h8000_0000, 3'b010, 5'd3,  64'hFFFF_FFFF_FFFF_F000, 1'b0};
    vt[3]  = '{32'h8000_0000, 3'b100, 5'd4,  64'hFFFF_FFFF_FFF0_0000, 1'b0};
    vt[4]  = '{32'h1234_5037, 3'b011, 5'd5,  64'h0000_0000_1234_5000, 1'b0};
    vt[5]  = '{32'h8000_0037, 3'b011, 5'd6,  64'hFFFF_FFFF_8000_0000, 1'b0};
    vt[6]  = '{32'h7FF0_0013, 3'b000, 5'd7,  64'h0000_0000_0000_07FF, 1'b0};
    vt[7]  = '{32'hFE00_0F80, 3'b001, 5'd8,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vt[8]  = '{32'h7E00_0F80, 3'b010, 5'd9,  64'h0000_0000_0000_0FFE, 1'b0};
    vt[9]  = '{32'h7FFF_F000, 3'b100, 5'd10, 64'h0000_0000_000F_FFFE, 1'b0};
`ifdef ZICSR_IMM_EN
    vt[10] = '{32'h800F_8073, 3'b101, 5'd11, 64'h0000_0000_0000_001F, 1'b0};
`else
    vt[10] = '{32'h800F_8073, 3'b101, 5'd11, 64'h0, 1'b1};
`endif
    vt[11] = '{32'hFFFF_FFFF, 3'b111, 5'd12, 64'h0, 1'b1};
    vt[12] = '{32'hFFFF_FFFF, 3'b110, 5'd13, 64'h0, 1'b1};

    rst_n = 1'b0; instr = '0; src = '0; tag = '0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", {63'b0, ov32}, 64'd0);
    chk("rst_imm",       {32'b0, imm32}, 64'd0);
    chk("rst_in_ready",  {63'b0, rdy32}, 64'd1);
    rst_n = 1'b1;
    step();
    chk("idle_out_valid", {63'b0, ov32}, 64'd0);

    // Back-to-back stream: each vector appears one edge after it is offered.
    for (int k = 0; k < NV; k++) begin
      in_valid = 1'b1; instr = vt[k].instr; src = vt[k].src; tag = vt[k].tag;
      step();
      chk($sformatf("v%0d_valid", k), {63'b0, ov32}, 64'd1);
      chk($sformatf("v%0d_imm32", k), {32'b0, imm32}, {32'b0, vt[k].exp[31:0]});
      chk($sformatf("v%0d_imm64", k), imm64, vt[k].exp);
      chk($sformatf("v%0d_tag", k), {59'b0, tage32}, {59'b0, vt[k].tag});
      chk($sformatf("v%0d_ill", k), {62'b0, ill64, ill32}, {62'b0, vt[k].ill, vt[k].ill});
    end
    in_valid = 1'b0;
    step();
    chk("drain_empty", {63'b0, ov32}, 64'd0);

    // Backpressure: 1 in main, 2 in skid, 3 held by the producer.
    out_ready = 1'b0;
    send(5'd1); step();
    chk("bp_main_tag", {59'b0, tage32}, 64'd1);
    chk("bp_rdy_1", {63'b0, rdy32}, 64'd1);
    send(5'd2); step();
    chk("bp_rdy_0", {63'b0, rdy32}, 64'd0);
    chk("bp_hold_tag", {59'b0, tage32}, 64'd1);
    send(5'd3); step();
    chk("bp_still_1", {59'b0, tage32}, 64'd1);
    chk("bp_still_rdy0", {63'b0, rdy32}, 64'd0);
    out_ready = 1'b1; step();
    chk("bp_out_2", {58'b0, ov32, tage32}, {58'b0, 1'b1, 5'd2});
    step();
    chk("bp_out_3", {58'b0, ov32, tage32}, {58'b0, 1'b1, 5'd3});
    in_valid = 1'b0; step();
    chk("bp_empty", {63'b0, ov32}, 64'd0);

    // Flush with both entries full; the input offered alongside is dropped.
    out_ready = 1'b0;
    send(5'd10); step();
    send(5'd11); step();
    send(5'd12); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", {63'b0, ov32}, 64'd0);
    chk("fl_in_ready", {63'b0, rdy32}, 64'd1);
    chk("fl_data_kept", {59'b0, tage32}, 64'd10);
    out_ready = 1'b1; step();
    chk("fl_no_12", {63'b0, ov32}, 64'd0);
    send(5'd13); step();
    chk("fl_next", {58'b0, ov32, tage32}, {58'b0, 1'b1, 5'd13});

    // Flush together with a consuming out_ready.
    send(5'd14); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_rdy_valid", {63'b0, ov32}, 64'd0);

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    send(5'd20); step();
    send(5'd21); step();
    in_valid = 1'b0;
    rst_n = 1'b0; #2;
    chk("mrst_out_valid", {63'b0, ov32}, 64'd0);
    chk("mrst_fields", {26'b0, imm32, tage32, ill32}, 64'd0);
    chk("mrst_in_ready", {63'b0, rdy32}, 64'd1);
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    send(5'd22); step();
    in_valid = 1'b0;
    chk("mrst_resume", {58'b0, ov32, tage32}, {58'b0, 1'b1, 5'd22});
    step();
    chk("mrst_empty", {63'b0, ov32}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, registered immediate generator for the decode-to-execute boundary. It extends the decode-stage immediate extraction from the I and S formats to I/S/B/U/J, with XLEN of 32 or 64. A valid/ready skid buffer provides stall and flush handling, and a sideband tag travels with each immediate. The block sits between the decode stage and the ID/EX register consumers.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; the immediate is sign-extended to XLEN.
TAG_W, 5, width of the sideband tag carried alongside each immediate (e.g. rd index).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset; asynchronous assert, active-low.
Instrd  in  32  decode-stage instruction word.
Immsrc  in  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (optional), 110/111 reserved.
Tagd  in  TAG_W  sideband tag; passes through unmodified.
in_valid  in  1  Instrd/Immsrc/Tagd valid this cycle.
in_ready  out  1  block can accept input; a transfer occurs when in_valid && in_ready.
flush  in  1  synchronous kill of all held entries.
Immextd  out  XLEN  extended immediate.
Tage  out  TAG_W  tag paired with Immextd.
imm_illegal  out  1  Immsrc was reserved or disabled; Immextd is 0.
out_valid  out  1  Immextd/Tage/imm_illegal valid.
out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.

Behaviour:
- Extraction, combinational before capture. s = Instrd[31] replicated to fill XLEN.
  - I: {s, Instrd[31:20]}
  - S: {s, Instrd[31:25], Instrd[11:7]}
  - B: {s, Instrd[7], Instrd[30:25], Instrd[11:8], 1'b0}
  - U: {s, Instrd[31:12], 12'b0}; for XLEN=64, bits 63:32 = s.
  - J: {s, Instrd[19:12], Instrd[20], Instrd[30:21], 1'b0}
  - Reserved: Immextd = 0, imm_illegal = 1.
- Storage: main register (drives the outputs) plus one skid register; each holds {Immext, tag, illegal, valid}.
- in_ready = !skid_valid, taken directly from a flop; no combinational path from out_ready.
- Latency: 1 cycle from an accepted input to out_valid when the buffer is empty.
- Throughput: 1 item per cycle while out_ready = 1.
- Per-cycle behaviour when flush = 0:
  - Main empty, or main draining this cycle, with skid empty: an accepted input loads main.
  - Main full and not draining, skid empty: an accepted input loads skid.
  - Main draining and skid full: skid moves to main and skid clears. No input can be accepted, since in_ready = 0.
- Ordering: strictly FIFO; no item is dropped or duplicated.
- Outputs are stable while out_valid && !out_ready.
- flush = 1: at the next edge, main_valid and skid_valid are 0. Input offered in the flush cycle is discarded. Output data registers are left unchanged.
- Flush and out_ready in the same cycle: the flush takes effect; the handshake in that cycle still counts as consumed.
- Reset (rst_n = 0) at any time, including mid-stall:
  - out_valid = 0, Immextd = 0, Tage = 0, imm_illegal = 0.
  - Skid register cleared; in_ready = 1.
  - Operation resumes on the first edge after release.
- The XLEN parameter affects extension width only; field positions are identical for 32 and 64.

Optional Feature:
Macro ZICSR_IMM_EN.
- Defined: Immsrc 101 selects the CSR zimm format: Immextd = zero-extended Instrd[19:15], imm_illegal = 0.
- Undefined: 101 is treated as reserved (Immextd = 0, imm_illegal = 1).

Test Plan:
- Reset release, XLEN=32: out_valid=0, Immextd=0, in_ready=1. Send I-type 0xFFF00093, Immsrc=000, Tagd=1 -> next cycle out_valid=1, Immextd=0xFFFFFFFF, Tage=1.
- Instrd=0x80000000 through S, B, J back-to-back with out_ready=1 -> Immextd 0xFFFFF800, 0xFFFFF000, 0xFFF00000 on consecutive cycles.
- U-type: 0x12345037 -> 0x12345000. With XLEN=64: 0x80000037 -> 0xFFFFFFFF80000000.
- Backpressure: out_ready=0, send tags 1, 2, 3 -> tag 1 at output, tag 2 in skid, in_ready=0, tag 3 held by producer. Raise out_ready -> outputs 1, 2, 3 in order, no gaps after the first.
- Flush with both entries full -> out_valid=0 and in_ready=1 next cycle; input offered in the flush cycle is absent from the output.
- Immsrc=101: with ZICSR_IMM_EN and Instrd[19:15]=0x1F -> Immextd=0x1F, imm_illegal=0. Without the macro -> Immextd=0, imm_illegal=1. Immsrc=111 -> imm_illegal=1.
